// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - PMA attribute/rule types and the shared range-check helper
package pma_pkg;

    localparam int PmaMaxRules     = 64;
    localparam int PmaMaxAddrWidth = 64;

    typedef struct packed {
        logic cache;
        logic exec;
        logic nonidem;
    } pma_attr_t;

    typedef struct packed {
        logic [PmaMaxAddrWidth-1:0] base;
        logic [PmaMaxAddrWidth-1:0] len;
        pma_attr_t                  attr;
        logic                       lock;
    } pma_rule_t;

    // The limit is formed one bit wider than the operands so that a region
    // reaching past the top of the address space does not alias to low addresses.
    function automatic logic range_check64(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] len);
        logic [64:0] limit;
        limit = {1'b0, base} + {1'b0, len};
        return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/pma_range_cmp.sv
// rtl/pma_range_cmp.sv - one PMA rule against one address
// Ports:
//   addr_i  address under test
//   base_i  rule base address
//   len_i   rule length (0 = rule disabled)
//   hit_o   address lies in [base, base+len)
module pma_range_cmp
    import pma_pkg::*;
#(
    parameter int AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] len_i,
    output logic                 hit_o
);

    // Narrower operands are zero-extended; the 65-bit limit cannot wrap for them.
    assign hit_o = range_check64(64'(addr_i), 64'(base_i), 64'(len_i));

endmodule

// File: rtl/pma_region_checker.sv
// rtl/pma_region_checker.sv - programmable, lockable, 2-stage pipelined PMA lookup
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   flush_i                           drop all in-flight lookups, block acceptance this cycle
//   req_valid_i/req_ready_o/req_addr_i   lookup request
//   resp_valid_o/resp_ready_i            lookup result handshake
//   resp_attr_o/resp_hit_o/resp_idx_o    attributes, hit flag, winning rule index
//   cfg_we_i/cfg_idx_i/cfg_rule_i        rule write port
//   cfg_err_o                         pulse after a rejected rule write
module pma_region_checker
    import pma_pkg::*;
#(
    parameter int                      NrRules     = 16,
    parameter int                      AddrWidth   = 64,
    parameter pma_attr_t               DefaultAttr = 3'b010,
    parameter pma_rule_t [NrRules-1:0] RstRules    = '0,
    localparam int                     RW          = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output pma_attr_t            resp_attr_o,
    output logic                 resp_hit_o,
    output logic [RW-1:0]        resp_idx_o,
    input  logic                 cfg_we_i,
    input  logic [RW-1:0]        cfg_idx_i,
    input  pma_rule_t            cfg_rule_i,
    output logic                 cfg_err_o
);

    localparam logic [RW:0] NrRulesW = (RW+1)'(NrRules);

    // ---------------- rule table ----------------
    pma_rule_t [NrRules-1:0] table_q;
    logic                    cfg_in_range;
    logic                    cfg_accept;
    logic                    cfg_err_q;

    assign cfg_in_range = ({1'b0, cfg_idx_i} < NrRulesW);
    // Locked rules can never be rewritten, which is what makes lock sticky.
    assign cfg_accept   = cfg_we_i && cfg_in_range && !table_q[cfg_idx_i].lock;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            table_q   <= RstRules;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i && !cfg_accept;
            for (int k = 0; k < NrRules; k++) begin
                if (cfg_accept && (cfg_idx_i == RW'(k))) begin
                    table_q[k] <= cfg_rule_i;
                end
            end
        end
    end

    assign cfg_err_o = cfg_err_q;

    // ---------------- compare (accept cycle) ----------------
    logic      [NrRules-1:0] hit_vec;
    pma_attr_t [NrRules-1:0] tbl_attr;

    for (genvar k = 0; k < NrRules; k++) begin : g_cmp
        pma_range_cmp #(.AddrWidth(AddrWidth)) u_cmp (
            .addr_i (req_addr_i),
            .base_i (table_q[k].base[AddrWidth-1:0]),
            .len_i  (table_q[k].len[AddrWidth-1:0]),
            .hit_o  (hit_vec[k])
        );
        assign tbl_attr[k] = table_q[k].attr;
    end

    // ---------------- handshake ----------------
    logic s1_valid_q, s2_valid_q;
    logic s1_ready, s2_ready;
    logic req_accept;

    assign s2_ready    = !s2_valid_q || resp_ready_i;
    assign s1_ready    = !s1_valid_q || s2_ready;
    assign req_ready_o = s1_ready && !flush_i;
    assign req_accept  = req_valid_i && req_ready_o;

    // ---------------- stage 1 ----------------
    // Attributes are snapshotted with the hit vector so that a rule rewrite
    // after acceptance cannot alter a lookup already in flight.
    logic      [NrRules-1:0] s1_hit_q;
    pma_attr_t [NrRules-1:0] s1_attr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_attr_q  <= '0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (s1_ready) begin
            s1_valid_q <= req_accept;
            if (req_accept) begin
                s1_hit_q  <= hit_vec;
                s1_attr_q <= tbl_attr;
            end
        end
    end

    // ---------------- priority encode: lowest hitting index wins ----------------
    pma_attr_t     enc_attr_d;
    logic          enc_hit_d;
    logic [RW-1:0] enc_idx_d;

    always_comb begin
        enc_attr_d = DefaultAttr;
        enc_hit_d  = 1'b0;
        enc_idx_d  = '0;
        for (int k = NrRules - 1; k >= 0; k--) begin
            if (s1_hit_q[k]) begin
                enc_attr_d = s1_attr_q[k];
                enc_hit_d  = 1'b1;
                enc_idx_d  = RW'(k);
            end
        end
    end

    // ---------------- stage 2 ----------------
    pma_attr_t     resp_attr_q;
    logic          resp_hit_q;
    logic [RW-1:0] resp_idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q  <= 1'b0;
            resp_attr_q <= '0;
            resp_hit_q  <= 1'b0;
            resp_idx_q  <= '0;
        end else if (flush_i) begin
            s2_valid_q <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                resp_attr_q <= enc_attr_d;
                resp_hit_q  <= enc_hit_d;
                resp_idx_q  <= enc_idx_d;
            end
        end
    end

    assign resp_valid_o = s2_valid_q;
    assign resp_attr_o  = resp_attr_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_idx_o   = resp_idx_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// tb/tb_pma_region_checker.sv - self-checking bench for pma_region_checker
module tb_pma_region_checker;
    import pma_pkg::*;

    localparam int NR = 12;
    localparam logic [2:0] A_NI = 3'b001;
    localparam logic [2:0] A_C  = 3'b100;
    localparam logic [2:0] A_DEF = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    pma_attr_t   resp_attr;
    logic        resp_hit;
    logic [3:0]  resp_idx;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    pma_rule_t   cfg_rule = '0;
    logic        cfg_err;

    int total = 0;
    int bad = 0;
    int nresp = 0;
    logic saw_stall;

    logic [7:0] exp_q[$];
    pma_rule_t  mdl[NR];

    always #5 clk = ~clk;

    pma_region_checker #(.NrRules(NR), .AddrWidth(64)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_attr_o(resp_attr), .resp_hit_o(resp_hit), .resp_idx_o(resp_idx),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_rule_i(cfg_rule), .cfg_err_o(cfg_err)
    );

    function automatic pma_rule_t mk(input logic [63:0] b, input logic [63:0] l,
                                     input logic [2:0] a, input logic lk);
        pma_rule_t r;
        r.base = b; r.len = l; r.attr = a; r.lock = lk;
        return r;
    endfunction

    function automatic logic [7:0] model_lookup(input logic [63:0] a);
        for (int k = 0; k < NR; k++) begin
            if (mdl[k].len != 0 && a >= mdl[k].base &&
                {1'b0, a} < ({1'b0, mdl[k].base} + {1'b0, mdl[k].len}))
                return {mdl[k].attr, 1'b1, 4'(k)};
        end
        return {A_DEF, 1'b0, 4'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every handshaken response is checked against the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                total++;
                nresp++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: got attr=%b hit=%b idx=%0d, no response expected",
                             resp_attr, resp_hit, resp_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({resp_attr, resp_hit, resp_idx} !== e) begin
                        bad++;
                        $display("FAIL resp_data: got attr=%b hit=%b idx=%0d, want attr=%b hit=%b idx=%0d",
                                 resp_attr, resp_hit, resp_idx, e[7:5], e[4], e[3:0]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model_lookup(a));
                step();
                req_valid = 1'b0;
                return;
            end
            saw_stall = 1'b1;
            step();
        end
        req_valid = 1'b0;
        total++; bad++;
        $display("FAIL req_timeout: addr=%h never accepted, want accept within 50 cycles", a);
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 50 && exp_q.size() != 0; t++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input pma_rule_t r);
        logic exp_err;
        exp_err = 1'b1;
        if (idx < NR) exp_err = mdl[idx].lock;
        cfg_we = 1'b1; cfg_idx = idx; cfg_rule = r;
        step();
        cfg_we = 1'b0;
        if (!exp_err) mdl[idx] = r;
        @(negedge clk);
        total++;
        if (cfg_err !== exp_err) begin
            bad++;
            $display("FAIL cfg_err idx=%0d: got %b, want %b", idx, cfg_err, exp_err);
        end
        step();
    endtask

    task automatic test_reset();
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, want 1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, want 0", resp_valid); end
        if ({resp_attr, resp_hit, resp_idx} !== 8'h00) begin
            bad++; $display("FAIL rst_resp: got %h, want 00", {resp_attr, resp_hit, resp_idx});
        end
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b, want 0", cfg_err); end
        step();
    endtask

    task automatic test_basic();
        cfg_write(4'd0, mk(64'h8000_0000, 64'h1000_0000, A_C, 1'b0));
        send(64'h8FFF_FFFF);
        send(64'h9000_0000);
        send(64'h7FFF_FFFF);
        drain();
    endtask

    task automatic test_overlap();
        cfg_write(4'd2, mk(64'h1000, 64'h100, A_NI, 1'b0));
        cfg_write(4'd5, mk(64'h1000, 64'h1000, A_C, 1'b0));
        send(64'h1080);
        send(64'h1180);
        send(64'h20FF);
        drain();
    endtask

    task automatic test_wrap();
        cfg_write(4'd8, mk(64'hFFFF_FFFF_FFFF_F000, 64'h2000, A_NI | A_C, 1'b0));
        send(64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h0);
        send(64'hFFFF_FFFF_FFFF_EFFF);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [8];
        int n0;
        addrs = '{64'h8000_0000, 64'h1080, 64'h1180, 64'h0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h9000_0000, 64'h1000, 64'h1FFF};
        saw_stall = 1'b0;
        n0 = nresp;
        fork
            begin
                for (int i = 0; i < 8; i++) send(addrs[i]);
            end
            begin
                repeat (2) @(posedge clk);
                #1 resp_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 resp_ready = 1'b1;
            end
        join
        drain();
        total += 2;
        if (saw_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall: req_ready never dropped, want a drop"); end
        if (nresp - n0 != 8) begin bad++; $display("FAIL b2b_count: got %0d responses, want 8", nresp - n0); end
    endtask

    task automatic test_lock();
        cfg_write(4'd3, mk(64'h4000, 64'h100, A_NI, 1'b1));
        cfg_write(4'd3, mk(64'h4000, 64'h100, A_C, 1'b0));
        send(64'h4010);
        cfg_write(4'd12, mk(64'h6000, 64'h100, A_C, 1'b0));
        cfg_write(4'd15, mk(64'h6000, 64'h100, A_C, 1'b0));
        send(64'h6010);
        drain();
    endtask

    task automatic test_cfg_same_cycle();
        cfg_write(4'd7, mk(64'h5000, 64'h100, A_NI, 1'b0));
        cfg_we = 1'b1; cfg_idx = 4'd7; cfg_rule = mk(64'h5000, 64'h100, A_C, 1'b0);
        send(64'h5010);
        cfg_we = 1'b0;
        mdl[7] = mk(64'h5000, 64'h100, A_C, 1'b0);
        send(64'h5010);
        drain();
    endtask

    task automatic test_flush();
        int n0;
        resp_ready = 1'b0;
        send(64'h1080);
        send(64'h8000_0000);
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 64'h1180;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b, want 0", req_ready); end
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        resp_ready = 1'b1;
        n0 = nresp;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b, want 0", resp_valid); end
        end
        step();
        total++;
        if (nresp != n0) begin bad++; $display("FAIL flush_count: got %0d responses, want 0", nresp - n0); end
    endtask

    task automatic test_async_reset();
        send(64'h8000_0000);
        #2 rst = 1'b1;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b, want 0", resp_valid); end
        exp_q.delete();
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        step();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL arst_drop: got %b, want 0", resp_valid); end
        end
        step();
        send(64'h8000_0000);
        send(64'h1080);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_wrap();
        test_back_to_back();
        test_lock();
        test_cfg_same_cycle();
        test_flush();
        test_async_reset();
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
